vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
- Scan-out controller for the VGA screen peripheral.
- Generates horizontal and vertical timing and fetches pixels in raster order from a framebuffer read port with fixed 1-cycle read latency.
- Drives the screen's hsync, vsync and 4-bit R, G and B pins, with sync pipelined to match pixel data.
- Sits between the framebuffer SRAM and the screen model; software starts and stops scan-out via `en`.

Parameters:
- H_ACTIVE, 400, visible pixels per line
- H_FP, 20, horizontal front porch (clocks)
- H_SYNC, 64, hsync pulse width (clocks)
- H_BP, 44, horizontal back porch (clocks)
- V_ACTIVE, 300, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 12, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- AW, 17, framebuffer word-address width (must be at least clog2(H_ACTIVE*V_ACTIVE))

Ports:
- clock  in  1  sole clock, one pixel per cycle
- resetn  in  1  asynchronous active-low reset
- en  in  1  scan-out enable, level
- fb_ren  out  1  framebuffer read strobe
- fb_raddr  out  AW  framebuffer word address
- fb_rdata  in  32  pixel 0x00RRGGBB, valid the cycle after fb_ren
- dat_hsync  out  1  horizontal sync to screen
- dat_vsync  out  1  vertical sync to screen
- dat_vga_r  out  4  red (fb_rdata[23:20])
- dat_vga_g  out  4  green (fb_rdata[15:12])
- dat_vga_b  out  4  blue (fb_rdata[7:4])
- busy  out  1  high while in RUN state
- frame_done  out  1  one-cycle pulse at the last counter position of each frame

Behaviour:

Definitions:
- HT = H_ACTIVE+H_FP+H_SYNC+H_BP (528); VT = V_ACTIVE+V_FP+V_SYNC+V_BP (315).
- Counters hcnt in [0, HT-1] and vcnt in [0, VT-1]; hcnt wraps to 0 and increments vcnt; vcnt wraps to 0 at VT-1.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- hsync active when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync active when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, over whole lines.

State machine (IDLE, RUN):
- IDLE: hcnt=vcnt=0; fb_ren=0; pipeline is fed sync-inactive and black.
- IDLE -> RUN on the first cycle with en=1; the next cycle has hcnt=0, vcnt=0.
- RUN: counters advance every cycle.
- en is sampled only at the frame end (hcnt=HT-1, vcnt=VT-1). If en=0 there, go to IDLE; otherwise continue into the next frame. A mid-frame en drop always completes the current frame.
- frame_done=1 in the cycle where RUN is at hcnt=HT-1, vcnt=VT-1.

Fetch:
- fb_ren is asserted combinationally from the counter flops in RUN when in the active region.
- fb_raddr comes from a dedicated address register, not a multiplier:
  - reset to 0 at frame start (hcnt=0, vcnt=0);
  - incremented after each active cycle.
- Addresses therefore run 0..H_ACTIVE*V_ACTIVE-1 (119999) contiguously per frame.
- fb_raddr is 0 whenever fb_ren=0.

Pipeline and latency:
- Stage 1: registers active/hsync/vsync from counter state.
- Stage 2: output registers. dat_vga_* take fb_rdata nibbles if the stage-1 active bit is set, else 0; dat_hsync and dat_vsync take the stage-1 syncs.
- Pin latency: a counter position at cycle t appears on the pins at t+2.
- On RUN->IDLE the pipeline drains naturally in 2 cycles.

Reset:
- Asynchronous, active-low, any time including mid-frame.
- Values: state=IDLE, counters 0, address 0, pipeline cleared, fb_ren=0, fb_raddr=0, dat_vga_*=0, dat_hsync=dat_vsync=~SYNC_POL (inactive), busy=0, frame_done=0.
- Release resumes in IDLE; if en=1, the frame restarts from address 0.

Width rules:
- Counters are clog2(HT) and clog2(VT) bits.
- The address counter does not wrap inside a frame.
- fb_rdata bits other than the selected MSB nibbles are ignored.

Test Plan:
1. Reset with en=0 for 10 cycles, then release: all pins at reset values (hsync=vsync=1, rgb=0, fb_ren=0, busy=0) and held while en=0.
2. Raise en at cycle T: busy=1 at T+1; fb_ren=1 with fb_raddr=0 at T+1; pixel with fb_rdata=0x00A5C3F0 → r=0xA, g=0xC, b=0xF at T+3; fb_raddr=399 at T+400; fb_ren=0 at T+401.
3. Line timing: hsync low for exactly 64 cycles, starting 420 cycles after line start plus 2 pipeline cycles; period 528 cycles; rgb=0 outside active.
4. Frame timing: vsync low for exactly 2×528 cycles, starting 301 lines after frame start; frame_done pulses every 528×315=166320 cycles; last active address 119999; next frame restarts at 0.
5. Drop en at mid-frame (line 150): frame completes to line 314; frame_done pulses; busy=0 next cycle; pins return to inactive 2 cycles later; no fetches thereafter.
6. Assert resetn=0 mid-line during an active pixel: all outputs go to reset values immediately (asynchronous, no clock edge); after release with en=1, the first fetch is address 0.

Source files
------------

// File: rtl/vga_ctrl_if.sv
// Framebuffer read port plus screen pins of the VGA scan-out controller.
// The controller takes the master side; framebuffer and screen take the slave side.
interface vga_ctrl_if #(
    parameter int AW = 17
);
    logic          fb_ren;
    logic [AW-1:0] fb_raddr;
    logic [31:0]   fb_rdata;
    logic          dat_hsync;
    logic          dat_vsync;
    logic [3:0]    dat_vga_r;
    logic [3:0]    dat_vga_g;
    logic [3:0]    dat_vga_b;

    modport master (
        output fb_ren,
        output fb_raddr,
        input  fb_rdata,
        output dat_hsync,
        output dat_vsync,
        output dat_vga_r,
        output dat_vga_g,
        output dat_vga_b
    );

    modport slave (
        input  fb_ren,
        input  fb_raddr,
        output fb_rdata,
        input  dat_hsync,
        input  dat_vsync,
        input  dat_vga_r,
        input  dat_vga_g,
        input  dat_vga_b
    );
endinterface

// File: rtl/vga_ctrl.sv
// VGA scan-out: raster counters, framebuffer fetch with 1-cycle read latency,
// and a 2-stage pin pipeline that keeps sync aligned with pixel data.
module vga_ctrl #(
    parameter int H_ACTIVE = 400,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 64,
    parameter int H_BP     = 44,
    parameter int V_ACTIVE = 300,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 12,
    parameter bit SYNC_POL = 1'b0,
    parameter int AW       = 17
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    vga_ctrl_if.master bus,
    output logic       busy,
    output logic       frame_done
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST  = HW'(HT - 1);
    localparam logic [HW-1:0] H_AEND  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(VT - 1);
    localparam logic [VW-1:0] V_AEND  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          frame_end;
    logic          active;
    logic          hs_on;
    logic          vs_on;

    logic          vld_p1;
    logic          hs_p1;
    logic          vs_p1;
    logic [3:0]    r_p2, g_p2, b_p2;
    logic          hsync_p2;
    logic          vsync_p2;

    // Only the top nibble of each colour byte reaches the 4-bit DAC pins.
    function automatic logic [11:0] gate_rgb(input logic vld, input logic [31:0] px);
        return vld ? {px[23:20], px[15:12], px[7:4]} : 12'h000;
    endfunction

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        addr_d    = addr_q;
        frame_end = 1'b0;
        active    = 1'b0;
        hs_on     = 1'b0;
        vs_on     = 1'b0;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                addr_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                active    = (hcnt_q < H_AEND) && (vcnt_q < V_AEND);
                hs_on     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
                vs_on     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
                frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
                if (active) addr_d = addr_q + AW'(1);
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
                // en only matters here, so a mid-frame drop still finishes the frame.
                if (frame_end) begin
                    addr_d = '0;
                    if (!en) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            addr_q  <= addr_d;
        end
    end

    // Stage 1: timing flags, aligned with fb_rdata returning for this position.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            vld_p1 <= active;
            hs_p1  <= hs_on;
            vs_p1  <= vs_on;
        end
    end

    // Stage 2: pin registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_p2     <= 4'h0;
            g_p2     <= 4'h0;
            b_p2     <= 4'h0;
            hsync_p2 <= ~SYNC_POL;
            vsync_p2 <= ~SYNC_POL;
        end else begin
            {r_p2, g_p2, b_p2} <= gate_rgb(vld_p1, bus.fb_rdata);
            hsync_p2 <= hs_p1 ? SYNC_POL : ~SYNC_POL;
            vsync_p2 <= vs_p1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.fb_ren    = active;
    assign bus.fb_raddr  = active ? addr_q : '0;
    assign bus.dat_vga_r = r_p2;
    assign bus.dat_vga_g = g_p2;
    assign bus.dat_vga_b = b_p2;
    assign bus.dat_hsync = hsync_p2;
    assign bus.dat_vsync = vsync_p2;
    assign busy          = (state_q == RUN);
    assign frame_done    = frame_end;
endmodule

// File: tb/tb_vga_ctrl.sv
// Randomized bench for vga_ctrl on a reduced raster, checked every cycle
// against a linear-position model of the scan timing.
module tb_vga_ctrl;
    localparam int HA = 12, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam bit POL = 1'b0;
    localparam int AWB = 7;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } desc_t;

    localparam desc_t IDLE_D = '{act: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 12'h000};

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic en = 1'b0;
    logic busy, frame_done;

    vga_ctrl_if #(.AW(AWB)) bus ();

    vga_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .AW(AWB)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .en(en),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] seed;
    logic [31:0] rd_next;
    bit          running;
    int          p;
    desc_t       pipe[$];
    desc_t       pins;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix(input int a);
        return (32'(a) * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic desc_t cur_desc();
        desc_t d;
        int h, v;
        logic [31:0] px;
        h = p % HT;
        v = p / HT;
        d.act = running && h < HA && v < VA;
        d.hs  = running && h >= HA + HF && h < HA + HF + HS;
        d.vs  = running && v >= VA + VF && v < VA + VF + VS;
        px    = pix(v * HA + h);
        d.rgb = d.act ? {px[23:20], px[15:12], px[7:4]} : 12'h000;
        return d;
    endfunction

    task automatic model_reset();
        running = 1'b0;
        p = 0;
        pipe.delete();
        pipe.push_back(IDLE_D);
        pins = IDLE_D;
    endtask

    task automatic advance();
        if (!resetn) begin
            model_reset();
            return;
        end
        pipe.push_back(cur_desc());
        pins = pipe.pop_front();
        if (!running) begin
            if (en) begin
                running = 1'b1;
                p = 0;
            end
        end else if (p == FRAME - 1) begin
            p = 0;
            if (!en) running = 1'b0;
        end else begin
            p++;
        end
    endtask

    task automatic check_outputs();
        desc_t d;
        int h, v;
        d = cur_desc();
        h = p % HT;
        v = p / HT;
        chk("busy", 32'(busy), 32'(running));
        chk("frame_done", 32'(frame_done), 32'(running && p == FRAME - 1));
        chk("fb_ren", 32'(bus.fb_ren), 32'(d.act));
        chk("fb_raddr", 32'(bus.fb_raddr), d.act ? 32'(v * HA + h) : 32'h0);
        chk("hsync", 32'(bus.dat_hsync), 32'(pins.hs ? POL : !POL));
        chk("vsync", 32'(bus.dat_vsync), 32'(pins.vs ? POL : !POL));
        chk("rgb", 32'({bus.dat_vga_r, bus.dat_vga_g, bus.dat_vga_b}), 32'(pins.rgb));
    endtask

    task automatic cycle();
        @(posedge clock);
        advance();
        #1 bus.fb_rdata = rd_next;
        @(negedge clock);
        check_outputs();
        rd_next = bus.fb_ren ? pix(int'(bus.fb_raddr)) : $urandom;
    endtask

    initial begin
        int guard;
        seed = $urandom;
        rd_next = 32'h0;
        bus.fb_rdata = 32'h0;
        model_reset();
        #1 resetn = 1'b0;

        // Reset held with en low, then idle after release.
        repeat (10) cycle();
        resetn = 1'b1;
        repeat (30) cycle();

        // Two full frames and into a third.
        en = 1'b1;
        repeat (2 * FRAME + 40) cycle();

        // Drop en mid-frame; the frame must complete, then stay idle.
        guard = 0;
        while (!(running && p / HT == VA / 2) && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        chk("reach_mid_frame", 32'(guard < 2 * FRAME), 32'h1);
        en = 1'b0;
        repeat (FRAME + 30) cycle();

        // Random en activity.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            cycle();
        end

        // Asynchronous reset in the middle of an active pixel.
        en = 1'b1;
        guard = 0;
        while (!(running && (p % HT) > 3 && (p % HT) < HA && (p / HT) < VA) && guard < 3 * FRAME) begin
            cycle();
            guard++;
        end
        chk("reach_active", 32'(guard < 3 * FRAME), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_frame_done", 32'(frame_done), 32'h0);
        chk("arst_fb_ren", 32'(bus.fb_ren), 32'h0);
        chk("arst_fb_raddr", 32'(bus.fb_raddr), 32'h0);
        chk("arst_hsync", 32'(bus.dat_hsync), 32'(!POL));
        chk("arst_vsync", 32'(bus.dat_vsync), 32'(!POL));
        chk("arst_rgb", 32'({bus.dat_vga_r, bus.dat_vga_g, bus.dat_vga_b}), 32'h0);
        model_reset();
        repeat (4) cycle();
        resetn = 1'b1;
        repeat (FRAME + 20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
